// File: rtl/divn_tick_sched.sv
// divn_tick_sched: programmable divide-by-N tick engine whose periodic tick
// is shared among NREQ requesters by round-robin arbitration. Divisor
// updates arrive over a valid/ready port and only take effect on a tick
// boundary (or directly while idle), so the tick period never glitches.
module divn_tick_sched #(
    parameter int NREQ    = 4,
    parameter int DIVW    = 4,
    parameter int DIV_RST = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic            i_cfg_valid,
    input  logic [DIVW-1:0] i_cfg_div,
    output logic            o_cfg_ready,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_tick,
    output logic            o_idle_tick,
    output logic            o_busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [DIVW-1:0] r_cnt;
    logic [DIVW-1:0] r_div;
    logic [DIVW-1:0] r_pend;
    logic            r_pend_v;
    logic [PTRW-1:0] r_rr_ptr;

    logic [DIVW-1:0] w_div_last;
    logic            w_run;
    logic            w_tick;
    logic            w_accept;
    logic            w_found;
    logic [PTRW-1:0] w_gidx;
    logic [PTRW-1:0] w_idx;

    // Terminal count: a stored divisor of 0 behaves like 1.
    assign w_div_last = (r_div == '0) ? '0 : r_div - DIVW'(1);
    assign w_run      = (r_state == ST_RUN);
    assign w_tick     = w_run && (r_cnt == w_div_last);
    assign w_accept   = i_cfg_valid && !r_pend_v;

    assign o_cfg_ready = !r_pend_v;
    assign o_tick      = w_tick;
    assign o_busy      = w_run;
    assign o_gnt       = (w_tick && w_found) ? (NREQ'(1) << w_gidx) : '0;
    assign o_idle_tick = w_tick && !w_found;

    // Round-robin search: first set request strictly after the last grant.
    always_comb begin
        // NOTE: every variable written here gets a default first, otherwise
        // paths that skip an assignment infer a latch.
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = PTRW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    // State, counter, divisor staging and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_div    <= DIVW'(DIV_RST);
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_rr_ptr <= PTRW'(NREQ - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_div <= i_cfg_div;
                    end
                    if (i_en) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_found) begin
                            r_rr_ptr <= w_gidx;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIVW'(1);
                    end

                    // A staged divisor lands at the tick edge; one accepted
                    // during this tick waits for the following tick.
                    if (w_tick && r_pend_v) begin
                        r_div    <= r_pend;
                        r_pend_v <= 1'b0;
                    end
                    if (w_accept) begin
                        r_pend   <= i_cfg_div;
                        r_pend_v <= 1'b1;
                    end

                    // Leaving RUN: nothing stays staged, the divisor is
                    // applied on entry to IDLE.
                    if (!i_en) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (w_accept) begin
                            r_div    <= i_cfg_div;
                            r_pend_v <= 1'b0;
                        end else if (r_pend_v) begin
                            r_div    <= r_pend;
                            r_pend_v <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divn_tick_sched.sv
// Self-checking bench for divn_tick_sched: table-driven arbitration vectors
// followed by hand-written config, idle-entry and reset sequences.
module tb_divn_tick_sched;

    localparam int NREQ = 4;
    localparam int DIVW = 4;

    logic            clk;
    logic            reset;
    logic            en;
    logic            cfg_valid;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_ready;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            tick;
    logic            idle_tick;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic            en;
        logic [NREQ-1:0] req;
        logic            exp_tick;
        logic [NREQ-1:0] exp_gnt;
        logic            exp_idle;
        logic            exp_busy;
        logic            exp_ready;
    } vec_t;

    vec_t vecs[$];

    divn_tick_sched #(
        .NREQ   (NREQ),
        .DIVW   (DIVW),
        .DIV_RST(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (en),
        .i_cfg_valid(cfg_valid),
        .i_cfg_div  (cfg_div),
        .o_cfg_ready(cfg_ready),
        .i_req      (req),
        .o_gnt      (gnt),
        .o_tick     (tick),
        .o_idle_tick(idle_tick),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs sampled at the falling edge.
    task automatic drive(input logic r, input logic e, input logic cv,
                         input logic [DIVW-1:0] cd, input logic [NREQ-1:0] rq);
        reset     = r;
        en        = e;
        cfg_valid = cv;
        cfg_div   = cd;
        req       = rq;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // n RUN cycles starting at cnt 0 with req=0: tick only in the last one,
    // and every tick is idle.
    task automatic run_period(input string name, input int n, input logic exp_ready);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0, '0);
            check($sformatf("%s c%0d tick", name, i), 32'(tick), 32'(i == n - 1));
            check($sformatf("%s c%0d idle", name, i), 32'(idle_tick), 32'(i == n - 1));
            check($sformatf("%s c%0d busy", name, i), 32'(busy), 32'd1);
            check($sformatf("%s c%0d ready", name, i), 32'(cfg_ready), 32'(exp_ready));
            adv();
        end
    endtask

    // One div=3 period: two non-tick cycles with the complement request
    // (must not matter), then the tick cycle with the real request.
    task automatic add_period(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] g);
        vecs.push_back('{1'b1, ~rq, 1'b0, '0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, ~rq, 1'b0, '0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, rq, 1'b1, g, (rq == '0), 1'b1, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; req = '0;
        repeat (2) @(posedge clk);
        #1;

        // Vector 0: first cycle after reset, still IDLE.
        vecs.push_back('{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1});
        add_period(4'b0001, 4'b0001);   // rr_ptr=3 -> search from 0
        add_period(4'b0001, 4'b0001);
        add_period(4'b1111, 4'b0010);
        add_period(4'b1111, 4'b0100);
        add_period(4'b1111, 4'b1000);
        add_period(4'b1111, 4'b0001);
        add_period(4'b1010, 4'b0010);
        add_period(4'b1010, 4'b1000);
        add_period(4'b1010, 4'b0010);   // rr_ptr=1 afterwards
        add_period(4'b0000, 4'b0000);   // idle tick, pointer unchanged
        add_period(4'b0000, 4'b0000);
        add_period(4'b0100, 4'b0100);   // search from 2 -> 2

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].en, 1'b0, '0, vecs[i].req);
            check($sformatf("v%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d idle", i), 32'(idle_tick), 32'(vecs[i].exp_idle));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d ready", i), 32'(cfg_ready), 32'(vecs[i].exp_ready));
            adv();
        end

        // Divisor 5 offered mid-period at div=3 (cnt=0 now).
        drive(1'b0, 1'b1, 1'b1, 4'd5, '0);
        check("cfg5 offer ready", 32'(cfg_ready), 32'd1);
        check("cfg5 offer tick", 32'(tick), 32'd0);
        adv();
        drive(1'b0, 1'b1, 1'b1, 4'd9, '0);   // held off while pending
        check("cfg9 held ready", 32'(cfg_ready), 32'd0);
        check("cfg9 held tick", 32'(tick), 32'd0);
        adv();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        check("old period tick", 32'(tick), 32'd1);
        check("old period ready", 32'(cfg_ready), 32'd0);
        adv();
        run_period("div5a", 5, 1'b1);
        run_period("div5b", 5, 1'b1);

        // Divisor 0 acts as 1; staged until the current 5-period ends.
        drive(1'b0, 1'b1, 1'b1, 4'd0, '0);
        check("cfg0 offer tick", 32'(tick), 32'd0);
        adv();
        run_period("div5 rest", 4, 1'b0);
        run_period("div0a", 1, 1'b1);
        run_period("div0b", 1, 1'b1);
        run_period("div0c", 1, 1'b1);

        // Divisor 1 offered in a tick cycle.
        drive(1'b0, 1'b1, 1'b1, 4'd1, '0);
        check("cfg1 offer tick", 32'(tick), 32'd1);
        check("cfg1 offer ready", 32'(cfg_ready), 32'd1);
        adv();
        run_period("cfg1 apply", 1, 1'b0);
        run_period("div1a", 1, 1'b1);
        run_period("div1b", 1, 1'b1);

        // Divisor 15 (maximum).
        drive(1'b0, 1'b1, 1'b1, 4'd15, '0);
        check("cfg15 offer tick", 32'(tick), 32'd1);
        adv();
        run_period("cfg15 apply", 1, 1'b0);
        run_period("div15a", 15, 1'b1);
        run_period("div15b", 15, 1'b1);

        // Stage 7, then reset: pending divisor must be lost.
        drive(1'b0, 1'b1, 1'b1, 4'd7, '0);
        check("cfg7 offer ready", 32'(cfg_ready), 32'd1);
        adv();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        check("cfg7 pending ready", 32'(cfg_ready), 32'd0);
        adv();
        drive(1'b1, 1'b1, 1'b0, '0, 4'b1111);
        adv();
        drive(1'b0, 1'b1, 1'b0, '0, 4'b1111);
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset tick", 32'(tick), 32'd0);
        check("post-reset gnt", 32'(gnt), 32'd0);
        check("post-reset ready", 32'(cfg_ready), 32'd1);
        adv();
        run_period("restart div3", 3, 1'b1);

        // Stage 6 in RUN, drop en: divisor applied on entry to IDLE.
        drive(1'b0, 1'b1, 1'b1, 4'd6, '0);
        check("cfg6 offer ready", 32'(cfg_ready), 32'd1);
        adv();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("leave run busy", 32'(busy), 32'd1);
        check("leave run tick", 32'(tick), 32'd0);
        adv();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        check("idle busy", 32'(busy), 32'd0);
        check("idle ready", 32'(cfg_ready), 32'd1);
        check("idle tick", 32'(tick), 32'd0);
        adv();
        run_period("div6", 6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divn_tick_sched.md
Name: divn_tick_sched

Overview:
- Sequences a programmable divide-by-N tick engine, the generalised, runtime-configurable form of the team's divide-by-3 FSM.
- Shares the resulting periodic tick among NREQ requesters using round-robin arbitration.
- Sits between the clock-enable fabric and slow peripherals that each need an occasional single-cycle enable.
- Divisor changes arrive over a valid/ready config port and take effect only on a tick boundary, so the period never glitches.

Parameters:
NREQ, 4, number of requesters (2..8)
DIVW, 4, width of divisor and internal counter
DIV_RST, 3, divisor loaded at reset (must be ≥1 and < 2**DIVW)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  run enable; high = generate ticks
cfg_valid  input  1  new divisor offered
cfg_div  input  DIVW  offered divisor; value 0 treated as 1
cfg_ready  output  1  divisor can be accepted this cycle
req  input  NREQ  per-requester request levels
gnt  output  NREQ  one-hot grant, one cycle, only in tick cycles
tick  output  1  one-cycle pulse every div clocks while running
idle_tick  output  1  tick occurred with req==0 (tick wasted)
busy  output  1  state==RUN

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset (sampled at clk edge), applied whatever the current state:
  - state=IDLE, cnt=0, div=DIV_RST, pend_v=0, rr_ptr=NREQ-1.
  - Outputs: tick=0, gnt=0, idle_tick=0, busy=0, cfg_ready=1 (first cycle after reset).
  - Any pending divisor is discarded.
- States:
  - IDLE: cnt held at 0, no ticks. en=1 → RUN at next edge.
  - RUN: cnt increments each cycle. en=0 → IDLE at next edge with cnt←0. A tick in that final cycle is still issued.
- Tick timing:
  - tick = (state==RUN) && (cnt==div_eff-1), where div_eff = (div==0)?1:div.
  - cnt wraps to 0 in the tick cycle.
  - With div=3, the first tick is in the 3rd RUN cycle, then every 3 cycles.
  - With div=1, tick is high every RUN cycle.
- Arbitration, combinational within the tick cycle:
  - Search req starting at index rr_ptr+1 (mod NREQ) and grant the first set bit.
  - rr_ptr ← granted index at the edge.
  - No set bit: gnt=0, idle_tick=1, rr_ptr unchanged.
  - gnt is never nonzero outside tick cycles.
  - req changes outside tick cycles have no effect.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pend_v. A single staging register is used.
  - In IDLE, an accepted divisor loads div directly at the edge; pend_v stays 0.
  - In RUN, an accepted divisor is stored in pend and pend_v←1.
  - At the next tick cycle's edge: div←pend, pend_v←0, cnt←0. The new period starts immediately after that tick.
  - A divisor accepted in the same cycle as a tick is staged and applies at the following tick, not the current one.
  - RUN→IDLE with pend_v=1: pend is applied to div on entry to IDLE.
- Width rules:
  - cnt is DIVW bits and compared against div_eff-1, so it never overflows.
  - Max divisor is 2**DIVW-1.

Test Plan:
1. Reset, en=1, div=3, req=4'b0001 → tick pulses every 3 cycles, first in RUN cycle 3; gnt=0001 with each tick; idle_tick=0.
2. req=4'b1111, 8 ticks at div=3 → gnt sequence 0001,0010,0100,1000,0001,…; req=4'b1010 → alternates 0010/1000.
3. RUN at div=3, offer cfg_div=5 mid-period → accepted (cfg_ready low until next tick); old 3-cycle period completes, then ticks every 5 cycles; second offer while pending is held off by cfg_ready=0.
4. cfg_div=0 and cfg_div=1 → tick every RUN cycle; cfg_div=15 → tick every 15 cycles.
5. req=0 during ticks → gnt=0, idle_tick pulses; then req=4'b0100 → next tick grants 0100 (rr_ptr unchanged by idle ticks).
6. Reset asserted mid-period with pend_v=1 → next cycle busy=0, tick=0, gnt=0, cfg_ready=1; pending divisor lost; div=3 on restart.
